// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state type and lane width for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int LANE_BITS = 2;
  typedef enum logic {S_IDLE, S_MERGE} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte/halfword lane extract with sign/zero extension for loads, lane merge for stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [LANE_BITS-1:0] lane,
  input  logic [31:0]          word,
  input  logic [31:0]          wdata,
  output logic [31:0]          ld_data,
  output logic [31:0]          st_word
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    ld_data = funct3[1] ? word :
              funct3[0] ? {{16{h[15] & ~funct3[2]}}, h} : {{24{b[7] & ~funct3[2]}}, b};
    st_word = word;
    if (funct3[1:0] == 2'b00) st_word[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (funct3[1:0] == 2'b01) st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores onto a word-addressed memory; SB/SH use a read-modify-write cycle.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of masking the low bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [LANE_BITS-1:0]  lane_q, lane_d;
  logic [2:0]            f3_q, f3_d;
  logic [31:0]           wdata_q, wdata_d, word_q, word_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_fault_q, rsp_fault_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  merge, accept, illegal, misalign, fault, sub_word;
  logic [31:0]           ld_data, st_word;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  // In MERGE the aligner sees the captured request; in IDLE it sees the live one.
  lsu_align u_align (
    .funct3 (f3_d),
    .lane   (lane_d),
    .word   (word_d),
    .wdata  (wdata_d),
    .ld_data(ld_data),
    .st_word(st_word)
  );

  always_comb begin
    merge    = state_q == S_MERGE;
    req_ready = !merge && !rst;
    accept   = req_valid && req_ready;
    illegal  = req_we ? req_funct3 > F3_W : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    fault    = illegal || misalign;
    sub_word = req_we && req_funct3 != F3_W;
    mem_a    = merge ? idx_q : req_addr[ADDR_WIDTH+1:2];
    idx_d    = mem_a;
    lane_d   = merge ? lane_q : req_addr[1:0];
    f3_d     = merge ? f3_q : req_funct3;
    wdata_d  = merge ? wdata_q : req_wdata;
    word_d   = merge ? word_q : mem_rd;
    mem_we   = !rst && (merge || (accept && req_we && !fault && !sub_word));
    mem_wd   = merge ? st_word : req_wdata;
    state_d  = (accept && req_we && !fault && sub_word) ? S_MERGE : S_IDLE;
    rsp_valid_d = merge || (accept && !(sub_word && !fault));
    rsp_fault_d = accept && fault;
    rsp_rdata_d = (accept && !req_we && !fault) ? ld_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
    idx_q   <= idx_d;
    lane_q  <= lane_d;
    f3_q    <= f3_d;
    wdata_q <= wdata_d;
    word_q  <= word_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand-written RMW, misalignment and reset sequences.
module tb_load_store_unit;
  import lsu_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [9:0]  mem_a;
  logic        mem_we;
  logic [31:0] mem_wd, mem_rd;
  logic [31:0] mem [1024];
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_val;
  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_we;
    logic        exp_fault;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a];
  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (mem_we) mem[mem_a] <= mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] val);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
  endtask

  task automatic add(input string n, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic ewe, input logic ef, input logic [31:0] erd);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd;
    v.exp_we = ewe; v.exp_fault = ef; v.exp_rdata = erd;
    vecs.push_back(v);
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    add("lb_17",    1'b0, F3_B,   32'h17,   32'h0,        1'b0, 1'b0, 32'hFFFFFF80);
    add("lbu_17",   1'b0, F3_BU,  32'h17,   32'h0,        1'b0, 1'b0, 32'h00000080);
    add("lh_16",    1'b0, F3_H,   32'h16,   32'h0,        1'b0, 1'b0, 32'hFFFF8070);
    add("lhu_14",   1'b0, F3_HU,  32'h14,   32'h0,        1'b0, 1'b0, 32'h000060F0);
    add("sw_20",    1'b1, F3_W,   32'h20,   32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    add("lw_20",    1'b0, F3_W,   32'h20,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF);
    add("ld_f011",  1'b0, 3'b011, 32'h00,   32'h0,        1'b0, 1'b1, 32'h0);
    add("ld_f110",  1'b0, 3'b110, 32'h04,   32'h0,        1'b0, 1'b1, 32'h0);
    add("st_f011",  1'b1, 3'b011, 32'h24,   32'hFFFFFFFF, 1'b0, 1'b1, 32'h0);
    add("lb_14",    1'b0, F3_B,   32'h14,   32'h0,        1'b0, 1'b0, 32'hFFFFFFF0);
    add("lbu_15",   1'b0, F3_BU,  32'h15,   32'h0,        1'b0, 1'b0, 32'h00000060);
    add("lw_wrap",  1'b0, F3_W,   32'h1000, 32'h0,        1'b0, 1'b0, 32'h12345678);
    add("st_f100",  1'b1, 3'b100, 32'h24,   32'hFFFFFFFF, 1'b0, 1'b1, 32'h0);
    add("lh_02",    1'b0, F3_H,   32'h02,   32'h0,        1'b0, 1'b0, 32'h00001234);

    @(negedge clk);
    poke(10'd0, 32'h12345678);
    poke(10'd5, 32'h807060F0);
    poke(10'd8, 32'hCAFEF00D);
    poke(10'd9, 32'h55555555);
    drive(1'b1, F3_W, 32'h24, 32'hAAAAAAAA);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_fault", {31'b0, rsp_fault}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_write", mem[9], 32'h55555555);

    for (int i = 0; i <= vecs.size(); i++) begin
      if (i > 0) begin
        chk({vecs[i-1].name, "_valid"}, {31'b0, rsp_valid}, 32'h1);
        chk({vecs[i-1].name, "_fault"}, {31'b0, rsp_fault}, {31'b0, vecs[i-1].exp_fault});
        chk({vecs[i-1].name, "_rdata"}, rsp_rdata, vecs[i-1].exp_rdata);
      end
      if (i < vecs.size()) begin
        drive(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
        #1;
        chk({vecs[i].name, "_ready"}, {31'b0, req_ready}, 32'h1);
        chk({vecs[i].name, "_mem_we"}, {31'b0, mem_we}, {31'b0, vecs[i].exp_we});
      end else req_valid = 1'b0;
      @(negedge clk);
    end
    chk("idle_valid", {31'b0, rsp_valid}, 32'h0);
    chk("fault_no_write", mem[9], 32'h55555555);

    drive(1'b1, F3_B, 32'h15, 32'h000000AB);
    #1;
    chk("sb_ready", {31'b0, req_ready}, 32'h1);
    chk("sb_acc_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    chk("sb_merge_ready", {31'b0, req_ready}, 32'h0);
    chk("sb_merge_we", {31'b0, mem_we}, 32'h1);
    chk("sb_merge_wd", mem_wd, 32'h8070ABF0);
    chk("sb_merge_a", {22'b0, mem_a}, 32'd5);
    chk("sb_merge_valid", {31'b0, rsp_valid}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("sb_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("sb_rsp_fault", {31'b0, rsp_fault}, 32'h0);
    chk("sb_rsp_rdata", rsp_rdata, 32'h0);
    chk("sb_ready_back", {31'b0, req_ready}, 32'h1);
    chk("sb_mem", mem[5], 32'h8070ABF0);

    drive(1'b1, F3_H, 32'h16, 32'h00001234);
    @(negedge clk);
    chk("sh_merge_wd", mem_wd, 32'h1234ABF0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("sh_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("sh_mem", mem[5], 32'h1234ABF0);

    drive(1'b1, F3_W, 32'h22, 32'h11223344);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_sw_we", {31'b0, mem_we}, 32'h0);
`else
    chk("mis_sw_we", {31'b0, mem_we}, 32'h1);
`endif
    @(negedge clk);
    drive(1'b0, F3_H, 32'h15, 32'h0);
    chk("mis_sw_valid", {31'b0, rsp_valid}, 32'h1);
    chk("mis_sw_rdata", rsp_rdata, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_sw_fault", {31'b0, rsp_fault}, 32'h1);
    chk("mis_sw_mem", mem[8], 32'hDEADBEEF);
`else
    chk("mis_sw_fault", {31'b0, rsp_fault}, 32'h0);
    chk("mis_sw_mem", mem[8], 32'h11223344);
`endif
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis_lh_valid", {31'b0, rsp_valid}, 32'h1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lh_fault", {31'b0, rsp_fault}, 32'h1);
    chk("mis_lh_rdata", rsp_rdata, 32'h0);
`else
    chk("mis_lh_fault", {31'b0, rsp_fault}, 32'h0);
    chk("mis_lh_rdata", rsp_rdata, 32'hFFFFABF0);
`endif
    @(negedge clk);

    drive(1'b1, F3_H, 32'h14, 32'h0000BEEF);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstm_mem_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstm_valid0", {31'b0, rsp_valid}, 32'h0);
    chk("rstm_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    chk("rstm_valid1", {31'b0, rsp_valid}, 32'h0);
    chk("rstm_mem", mem[5], 32'h1234ABF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the pipeline's memory stage and the word-addressed data memory (1024 × 32-bit, combinational read, synchronous word write). Converts RV32I byte/halfword/word loads and stores into whole-word memory accesses. Loads are sign- or zero-extended. Sub-byte-lane stores are a two-cycle read-modify-write. Every access returns a registered response one cycle after the access finishes.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-index width; memory depth is 2**ADDR_WIDTH words.

Ports:
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; combinational, high only in IDLE with rst low
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  access rejected (illegal funct3 or misaligned)
- mem_a  out  ADDR_WIDTH  word index = addr[ADDR_WIDTH+1:2]
- mem_we  out  1  word write enable
- mem_wd  out  32  word write data
- mem_rd  in  32  combinational read data for mem_a

## Operation
- FSM states: IDLE, MERGE.
- A request is accepted on a rising edge where req_valid && req_ready.
- mem_a:
  - IDLE: driven from req_addr.
  - MERGE: driven from the held index register.
- Load accepted in IDLE:
  - Extract the lane from mem_rd and extend it.
  - Register the result into rsp_rdata.
  - rsp_valid is high in the next cycle. Stay in IDLE.
- SW accepted in IDLE:
  - mem_we=1 and mem_wd=req_wdata in the accept cycle; the write commits at that edge.
  - rsp_valid is high in the next cycle.
- SB/SH accepted in IDLE:
  - Capture mem_rd, lane offset, funct3 and wdata. Go to MERGE.
- MERGE:
  - mem_we=1. mem_wd = captured word with the byte/halfword lane replaced.
  - req_ready=0.
  - Next edge: return to IDLE. rsp_valid is high in the following cycle.
- Lane rules:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Illegal funct3 raises a fault:
  - loads: 011, 110, 111
  - stores: 011–111
- A fault produces no memory write. rsp_fault=1 and rsp_rdata=0 in the response cycle.
- mem_we is gated by ~rst.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_fault=0, state=IDLE. During rst: req_ready=0, mem_we=0.
- Latency from accept edge to rsp_valid:
  - loads, SW, faults: 1 cycle
  - SB/SH: 2 cycles
- Throughput:
  - loads and SW: one per cycle, back to back.
  - SB/SH: one every 2 cycles.
- Reset during MERGE: no write occurs. Return to IDLE with no response.
- rsp_valid has no backpressure. The consumer must take it in the pulse cycle.
- Address bits above ADDR_WIDTH+1 are ignored, so the address wraps modulo the memory size.

## Configuration
- LSU_MISALIGN_TRAP_EN
  - Defined: these accesses are misaligned:
    - LH/LHU/SH with addr[0]=1
    - LW/SW with addr[1:0]≠0
  - A misaligned access is accepted, raises a fault (no write), and responds 1 cycle later with rsp_fault=1.
  - Not defined: misaligned low bits are masked (halfword uses addr[1], word uses index only). Only illegal funct3 raises a fault.

## Structure
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum (S_IDLE, S_MERGE)
  - LANE_BITS=2
- Sub-module lsu_align: combinational lane extract/extend for loads and lane merge for stores. Instantiated once in load_store_unit.

## Test plan
- Back-to-back loads:
  - Preload mem[5]=0x807060F0.
  - Issue LB 0x17, LBU 0x17, LH 0x16, LHU 0x14 in consecutive cycles.
  - Expect rsp_rdata 0xFFFFFF80, 0x00000080, 0xFFFF8070, 0x000060F0 on 4 consecutive rsp_valid cycles.
- SB read-modify-write:
  - mem[5]=0x807060F0; SB addr 0x15 wdata 0x000000AB.
  - Expect req_ready=0 one cycle, mem_we in that MERGE cycle with mem_wd=0x8070ABF0.
  - Expect rsp_valid 2 cycles after accept; mem[5]=0x8070ABF0.
- SW then LW same address:
  - SW 0x20 data 0xDEADBEEF, then LW 0x20 next cycle.
  - Expect rsp_rdata=0xDEADBEEF.
- Misaligned SW 0x22 data 0x11223344:
  - With LSU_MISALIGN_TRAP_EN: rsp_fault=1, no mem_we, mem[8] unchanged.
  - Without: mem[8]=0x11223344, rsp_fault=0.
- Illegal funct3:
  - Load funct3=011 at 0x00 → rsp_fault=1, rsp_rdata=0, 1-cycle latency.
- Reset during MERGE:
  - SH 0x14 data 0xBEEF accepted; assert rst in the MERGE cycle.
  - Expect mem_we=0, mem[5] unchanged, no rsp_valid, req_ready=1 the cycle after rst deasserts.
